imem_loader: RTL and testbench

Boot-time program loader that sits upstream of the instruction memory and the single-cycle CPU in `sccomp_dataflow`. It receives a program image as a byte stream (UART receiver or testbench) and assembles big-endian 32-bit words. It writes them sequentially into the IMEM write port from word address 0 and holds the CPU in reset until the image is fully written. Once loaded, it releases the CPU and ignores further input until the next reset.

---
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time IMEM loader: assembles a big-endian length-prefixed byte stream into 32-bit
// words, writes them from address 0 and holds the CPU in reset until done. Optional: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned CAPACITY = 1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_TAIL, S_DONE, S_ERR
  } state_t;
`endif

  state_t            state, state_nxt;
  logic [7:0]        len_hi;
  logic [23:0]       shift;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   word_last;
  logic [15:0]       len_word;
  logic              len_over;
  logic              len_zero;
  logic              xfer;
  logic              accept_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign xfer     = rx_valid && rx_ready;
  assign len_word = {len_hi, rx_data};
  assign len_over = 32'(len_word) > CAPACITY;
  assign len_zero = (len_word == 16'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_over)      state_nxt = S_ERR;
`ifdef IMEM_LOADER_CHECKSUM_EN
          else if (len_zero) state_nxt = S_CSUM;
`else
          else if (len_zero) state_nxt = S_TAIL;
`endif
          else               state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && byte_cnt == 2'd3 && word_cnt == word_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_TAIL;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum byte can only arrive after the last write has already been presented.
      S_CSUM: if (xfer) state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
`else
      S_TAIL: state_nxt = S_DONE;
`endif
      default: state_nxt = state;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign accept_nxt = (state_nxt == S_LEN_HI) || (state_nxt == S_LEN_LO) ||
                      (state_nxt == S_DATA)   || (state_nxt == S_CSUM);
`else
  assign accept_nxt = (state_nxt == S_LEN_HI) || (state_nxt == S_LEN_LO) ||
                      (state_nxt == S_DATA);
`endif

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state     <= S_LEN_HI;
      rx_ready  <= 1'b0;
      im_we     <= 1'b0;
      im_waddr  <= '0;
      im_wdata  <= '0;
      cpu_rst   <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      len_hi    <= '0;
      shift     <= '0;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      word_last <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= state_nxt;
      rx_ready  <= accept_nxt;
      im_we     <= 1'b0;
      cpu_rst   <= (state_nxt != S_DONE);
      load_done <= (state_nxt == S_DONE);
      load_err  <= (state_nxt == S_ERR);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (xfer) csum <= csum ^ rx_data;
`endif
      case (state)
        S_LEN_HI: if (xfer) len_hi <= rx_data;
        S_LEN_LO: begin
          if (xfer) begin
            word_last <= (ADDR_W+1)'(len_word - 16'd1);
            word_cnt  <= '0;
            byte_cnt  <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            shift    <= {shift[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              im_we    <= 1'b1;
              im_waddr <= word_cnt[ADDR_W-1:0];
              im_wdata <= {shift, rx_data};
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; follows IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;
  localparam int unsigned ADDR_W = 11;

  logic              clk_in = 1'b0;
  logic              reset = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  logic [7:0]  stream [10] = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00,
                               8'h05, 8'h08, 8'h10, 8'h00, 8'h00};
  int unsigned idle   [10] = '{1, 0, 3, 2, 0, 1, 3, 0, 2, 1};

  always #5 clk_in = ~clk_in;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .im_waddr  (im_waddr),
    .im_wdata  (im_wdata),
    .cpu_rst   (cpu_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always @(negedge clk_in) begin
    if (im_we === 1'b1) begin
      wr_addr.push_back(im_waddr);
      wr_data.push_back(im_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int unsigned tries = 0;
    logic got = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!got && tries < 20) begin
      got = rx_ready;
      @(negedge clk_in);
      tries++;
    end
    rx_valid = 1'b0;
    check("send_accept", 32'(got), 32'd1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk_in);
    wr_addr.delete();
    wr_data.delete();
    reset = 1'b0;
  endtask

  task automatic check_final_ok(input string tag);
    check({tag, "_cpu_rst"},   32'(cpu_rst),   32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd1);
    check({tag, "_load_err"},  32'(load_err),  32'd0);
    check({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
    check({tag, "_im_we"},     32'(im_we),     32'd0);
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check({tag, "_a0"}, 32'(wr_addr[0]), 32'd0);
      check({tag, "_d0"}, wr_data[0], 32'h24080005);
      check({tag, "_a1"}, 32'(wr_addr[1]), 32'd1);
      check({tag, "_d1"}, wr_data[1], 32'h08100000);
    end
  endtask

  task automatic send_image(input bit gaps);
    for (int i = 0; i < 10; i++) begin
      if (gaps) repeat (idle[i]) @(negedge clk_in);
      send_byte(stream[i]);
    end
  endtask

  task automatic run_stream(input string tag, input bit gaps);
    send_image(gaps);
    check({tag, "_last_we"},   32'(im_we),    32'd1);
    check({tag, "_last_addr"}, 32'(im_waddr), 32'd1);
    check({tag, "_last_data"}, im_wdata,      32'h08100000);
    check({tag, "_hold_rst"},  32'(cpu_rst),  32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h33);
`else
    @(negedge clk_in);
`endif
    check_final_ok(tag);
    @(negedge clk_in);
    check_two_writes(tag);
  endtask

  initial begin
    // Reset values while reset is held
    @(negedge clk_in);
    @(negedge clk_in);
    check("rst_rx_ready",  32'(rx_ready),  32'd0);
    check("rst_im_we",     32'(im_we),     32'd0);
    check("rst_im_waddr",  32'(im_waddr),  32'd0);
    check("rst_im_wdata",  im_wdata,       32'd0);
    check("rst_cpu_rst",   32'(cpu_rst),   32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err",  32'(load_err),  32'd0);
    reset = 1'b0;
    @(negedge clk_in);
    check("ready_after_rst", 32'(rx_ready), 32'd1);

    // Back-to-back stream
    run_stream("b2b", 1'b0);

    // Bytes offered after completion are ignored
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (4) @(negedge clk_in);
    rx_valid = 1'b0;
    check("done_ignore_ready", 32'(rx_ready), 32'd0);
    check("done_ignore_nwr",   32'(wr_addr.size()), 32'd2);
    check("done_ignore_done",  32'(load_done), 32'd1);

    // Same stream with idle gaps
    do_reset();
    run_stream("gaps", 1'b1);

    // Zero-length image
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`else
    check("zero_not_yet_done", 32'(load_done), 32'd0);
    @(negedge clk_in);
`endif
    check_final_ok("zero");
    @(negedge clk_in);
    check("zero_nwr", 32'(wr_addr.size()), 32'd0);

    // Exactly full capacity is accepted
    do_reset();
    send_byte(8'h08);
    send_byte(8'h00);
    check("cap_load_err", 32'(load_err), 32'd0);
    check("cap_rx_ready", 32'(rx_ready), 32'd1);
    check("cap_cpu_rst",  32'(cpu_rst),  32'd1);

    // One word over capacity
    do_reset();
    send_byte(8'h08);
    send_byte(8'h01);
    check("over_load_err",  32'(load_err),  32'd1);
    check("over_cpu_rst",   32'(cpu_rst),   32'd1);
    check("over_rx_ready",  32'(rx_ready),  32'd0);
    check("over_load_done", 32'(load_done), 32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (4) @(negedge clk_in);
    rx_valid = 1'b0;
    check("over_nwr",       32'(wr_addr.size()), 32'd0);
    check("over_err_stays", 32'(load_err), 32'd1);

    // Reset after 5 data bytes, then a full stream
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(stream[i]);
    @(negedge clk_in);
    check("mid_first_wr", 32'(wr_addr.size()), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_async_cpu_rst", 32'(cpu_rst),  32'd1);
    check("mid_async_ready",   32'(rx_ready), 32'd0);
    @(negedge clk_in);
    wr_addr.delete();
    wr_data.delete();
    reset = 1'b0;
    run_stream("mid", 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum byte
    do_reset();
    send_image(1'b0);
    send_byte(8'h34);
    check("bad_load_err",  32'(load_err),  32'd1);
    check("bad_cpu_rst",   32'(cpu_rst),   32'd1);
    check("bad_load_done", 32'(load_done), 32'd0);
    @(negedge clk_in);
    check_two_writes("bad");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
